// File: rtl/bp_fe_fetch_seq.sv
// Front-end fetch sequencer: issues sequential fetches into the 2-cycle
// ITLB/I$ stage, handles replay, ITLB-miss wait, faults and redirects.
module bp_fe_fetch_seq #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int pc_step_p     = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    input  logic                     itlb_fill_done_i,
    output logic                     mem_cmd_v_o,
    output logic [vaddr_width_p-1:0] mem_cmd_vaddr_o,
    input  logic                     mem_cmd_yumi_i,
    output logic                     mem_poison_o,
    input  logic                     mem_resp_v_i,
    input  logic                     mem_resp_icache_miss_i,
    input  logic                     mem_resp_itlb_miss_i,
    input  logic                     mem_resp_access_fault_i,
    input  logic                     mem_resp_page_fault_i,
    input  logic [instr_width_p-1:0] mem_resp_data_i,
    output logic                     fetch_v_o,
    output logic [vaddr_width_p-1:0] fetch_pc_o,
    output logic [instr_width_p-1:0] fetch_instr_o,
    input  logic                     fetch_ready_i,
    output logic                     exc_v_o,
    output logic [1:0]               exc_code_o,
    output logic [vaddr_width_p-1:0] exc_pc_o
);

    typedef enum logic [1:0] {
        e_run,
        e_itlb_wait,
        e_fault
    } state_e;

    state_e state_r, state_n;

    logic [vaddr_width_p-1:0] next_pc_r, next_pc_n;
    logic [vaddr_width_p-1:0] s1_pc_r, s2_pc_r;
    logic                     s1_v_r, s2_v_r;

    logic resp_v, cmd_accept;
    logic is_af, is_pf, is_itlb, is_icm, is_good;
    logic replay, flush;

    always_comb begin
        resp_v  = s2_v_r & mem_resp_v_i & ~redirect_v_i & ~reset_i;
        is_af   = resp_v & mem_resp_access_fault_i;
        is_pf   = resp_v & ~mem_resp_access_fault_i
                & mem_resp_page_fault_i;
        is_itlb = resp_v & ~mem_resp_access_fault_i
                & ~mem_resp_page_fault_i & mem_resp_itlb_miss_i;
        is_icm  = resp_v & ~mem_resp_access_fault_i
                & ~mem_resp_page_fault_i & ~mem_resp_itlb_miss_i
                & mem_resp_icache_miss_i;
        is_good = resp_v & ~is_af & ~is_pf & ~is_itlb & ~is_icm;
    end

    // A command accepted in the same cycle as a flush is dropped from s1,
    // so its response is ignored when it arrives.
    always_comb begin
        mem_cmd_v_o     = (state_r == e_run) & ~redirect_v_i & ~reset_i;
        mem_cmd_vaddr_o = next_pc_r;
        cmd_accept      = mem_cmd_v_o & mem_cmd_yumi_i;

        fetch_v_o     = is_good & fetch_ready_i;
        fetch_pc_o    = s2_pc_r;
        fetch_instr_o = fetch_v_o ? mem_resp_data_i : '0;

        exc_v_o  = is_af | is_pf | is_itlb;
        exc_pc_o = s2_pc_r;
        unique case (1'b1)
            is_af:   exc_code_o = 2'd1;
            is_pf:   exc_code_o = 2'd2;
            default: exc_code_o = 2'd0;
        endcase

        replay       = is_icm | is_itlb | (is_good & ~fetch_ready_i);
        flush        = redirect_v_i | replay | exc_v_o;
        mem_poison_o = s1_v_r & flush & ~reset_i;
    end

    always_comb begin
        state_n   = state_r;
        next_pc_n = next_pc_r;
        if (redirect_v_i) begin
            state_n   = e_run;
            next_pc_n = redirect_pc_i;
        end else begin
            unique case (state_r)
                e_run: begin
                    if (is_itlb) state_n = e_itlb_wait;
                    else if (is_af | is_pf) state_n = e_fault;
                end
                e_itlb_wait: begin
                    if (itlb_fill_done_i) state_n = e_run;
                end
                default: state_n = state_r;
            endcase
            if (replay) begin
                next_pc_n = s2_pc_r;
            end else if (cmd_accept) begin
                next_pc_n = next_pc_r + vaddr_width_p'(pc_step_p);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_run;
            next_pc_r <= '0;
            s1_v_r    <= 1'b0;
            s1_pc_r   <= '0;
            s2_v_r    <= 1'b0;
            s2_pc_r   <= '0;
        end else begin
            state_r   <= state_n;
            next_pc_r <= next_pc_n;
            s1_v_r    <= cmd_accept & ~flush;
            s2_v_r    <= s1_v_r & ~flush;
            s2_pc_r   <= s1_pc_r;
            if (cmd_accept) s1_pc_r <= next_pc_r;
        end
    end

endmodule

// File: tb/tb_bp_fe_fetch_seq.sv
// Directed bench for bp_fe_fetch_seq with a 2-cycle memory stage model
// that injects one-shot misses and address-matched faults.
module tb_bp_fe_fetch_seq;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        redirect_v_i;
    logic [38:0] redirect_pc_i;
    logic        itlb_fill_done_i;
    logic        mem_cmd_v_o;
    logic [38:0] mem_cmd_vaddr_o;
    logic        mem_cmd_yumi_i;
    logic        mem_poison_o;
    logic        mem_resp_v_i;
    logic        mem_resp_icache_miss_i;
    logic        mem_resp_itlb_miss_i;
    logic        mem_resp_access_fault_i;
    logic        mem_resp_page_fault_i;
    logic [31:0] mem_resp_data_i;
    logic        fetch_v_o;
    logic [38:0] fetch_pc_o;
    logic [31:0] fetch_instr_o;
    logic        fetch_ready_i;
    logic        exc_v_o;
    logic [1:0]  exc_code_o;
    logic [38:0] exc_pc_o;

    bp_fe_fetch_seq dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .redirect_v_i           (redirect_v_i),
        .redirect_pc_i          (redirect_pc_i),
        .itlb_fill_done_i       (itlb_fill_done_i),
        .mem_cmd_v_o            (mem_cmd_v_o),
        .mem_cmd_vaddr_o        (mem_cmd_vaddr_o),
        .mem_cmd_yumi_i         (mem_cmd_yumi_i),
        .mem_poison_o           (mem_poison_o),
        .mem_resp_v_i           (mem_resp_v_i),
        .mem_resp_icache_miss_i (mem_resp_icache_miss_i),
        .mem_resp_itlb_miss_i   (mem_resp_itlb_miss_i),
        .mem_resp_access_fault_i(mem_resp_access_fault_i),
        .mem_resp_page_fault_i  (mem_resp_page_fault_i),
        .mem_resp_data_i        (mem_resp_data_i),
        .fetch_v_o              (fetch_v_o),
        .fetch_pc_o             (fetch_pc_o),
        .fetch_instr_o          (fetch_instr_o),
        .fetch_ready_i          (fetch_ready_i),
        .exc_v_o                (exc_v_o),
        .exc_code_o             (exc_code_o),
        .exc_pc_o               (exc_pc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(logic [38:0] a);
        return a[31:0] ^ 32'h5A5A_1234;
    endfunction

    // memory stage model
    logic        m1_v = 1'b0, m2_v = 1'b0;
    logic [38:0] m1_a = '0, m2_a = '0;
    logic [38:0] ic_pc = 39'h1, tl_pc = 39'h1;
    logic [38:0] af_pc = 39'h1, pf_pc = 39'h1;
    int          ic_tok = 0, ic_done = 0;
    int          tl_tok = 0, tl_done = 0;
    logic        ic_hit, tl_hit;

    assign ic_hit = m2_v && m2_a == ic_pc && ic_tok != ic_done;
    assign tl_hit = m2_v && m2_a == tl_pc && tl_tok != tl_done;
    assign mem_resp_v_i            = m2_v;
    assign mem_resp_icache_miss_i  = ic_hit;
    assign mem_resp_itlb_miss_i    = tl_hit;
    assign mem_resp_access_fault_i = m2_v && m2_a == af_pc;
    assign mem_resp_page_fault_i   = m2_v && m2_a == pf_pc;
    assign mem_resp_data_i         = instr_of(m2_a);

    always @(posedge clk_i) begin
        if (reset_i) begin
            m1_v <= 1'b0;
            m2_v <= 1'b0;
        end else begin
            m1_v <= mem_cmd_v_o & mem_cmd_yumi_i;
            m1_a <= mem_cmd_vaddr_o;
            m2_v <= m1_v & ~mem_poison_o;
            m2_a <= m1_a;
            if (ic_hit) ic_done <= ic_tok;
            if (tl_hit) tl_done <= tl_tok;
        end
    end

    // output monitor
    logic [38:0] got[$];
    logic [38:0] cmds[$];
    logic [38:0] epc[$];
    int          both = 0, bad_instr = 0;

    always @(negedge clk_i) begin
        if (fetch_v_o) begin
            got.push_back(fetch_pc_o);
            if (fetch_instr_o !== instr_of(fetch_pc_o)) bad_instr++;
        end
        if (exc_v_o) epc.push_back(exc_pc_o);
        if (fetch_v_o && exc_v_o) both++;
        if (mem_cmd_v_o && mem_cmd_yumi_i) cmds.push_back(mem_cmd_vaddr_o);
    end

    int checks = 0, errors = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] at_got(int i);
        if (i < got.size()) return got[i];
        return 'x;
    endfunction

    function automatic logic [38:0] at_cmd(int i);
        if (i < cmds.size()) return cmds[i];
        return 'x;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic redirect_to(logic [38:0] pc);
        redirect_v_i  = 1'b1;
        redirect_pc_i = pc;
        tick(1);
        redirect_v_i  = 1'b0;
    endtask

    int b, bc, be;

    initial begin
        reset_i          = 1'b1;
        redirect_v_i     = 1'b0;
        redirect_pc_i    = '0;
        itlb_fill_done_i = 1'b0;
        mem_cmd_yumi_i   = 1'b0;
        fetch_ready_i    = 1'b1;
        tick(3);
        @(negedge clk_i);
        chk("rst_cmd_v", mem_cmd_v_o, 0);
        chk("rst_fetch_v", fetch_v_o, 0);
        chk("rst_exc_v", exc_v_o, 0);
        chk("rst_poison", mem_poison_o, 0);
        tick(1);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("run_cmd_v", mem_cmd_v_o, 1);
        chk("run_vaddr", mem_cmd_vaddr_o, 0);
        tick(1);
        mem_cmd_yumi_i = 1'b1;
        tick(3);

        // sequential stream after redirect
        b = got.size();
        redirect_to(39'h80000000);
        tick(2);
        @(negedge clk_i);
        chk("seq_first_v", fetch_v_o, 1);
        chk("seq_first_pc", fetch_pc_o, 39'h80000000);
        tick(3);
        chk("seq_pc1", at_got(b + 1), 39'h80000004);
        chk("seq_pc2", at_got(b + 2), 39'h80000008);

        // I$ miss on 0x1004
        ic_pc = 39'h1004;
        ic_tok++;
        b  = got.size();
        bc = cmds.size();
        redirect_to(39'h1000);
        tick(3);
        @(negedge clk_i);
        chk("icm_poison", mem_poison_o, 1);
        chk("icm_fetch_v", fetch_v_o, 0);
        tick(8);
        chk("icm_refetch", at_cmd(bc + 4), 39'h1004);
        chk("icm_pc0", at_got(b), 39'h1000);
        chk("icm_pc1", at_got(b + 1), 39'h1004);
        chk("icm_pc2", at_got(b + 2), 39'h1008);
        chk("icm_pc3", at_got(b + 3), 39'h100C);

        // fetch queue backpressure on 0x2008
        b = got.size();
        redirect_to(39'h2000);
        tick(4);
        fetch_ready_i = 1'b0;
        @(negedge clk_i);
        chk("bp_poison", mem_poison_o, 1);
        chk("bp_fetch_v", fetch_v_o, 0);
        tick(1);
        fetch_ready_i = 1'b1;
        tick(6);
        chk("bp_pc1", at_got(b + 1), 39'h2004);
        chk("bp_pc2", at_got(b + 2), 39'h2008);
        chk("bp_pc3", at_got(b + 3), 39'h200C);

        // ITLB miss at 0x3000
        tl_pc = 39'h3000;
        tl_tok++;
        b  = got.size();
        bc = cmds.size();
        be = epc.size();
        redirect_to(39'h3000);
        tick(2);
        @(negedge clk_i);
        chk("itlb_exc_v", exc_v_o, 1);
        chk("itlb_code", exc_code_o, 0);
        chk("itlb_pc", exc_pc_o, 39'h3000);
        chk("itlb_poison", mem_poison_o, 1);
        tick(3);
        @(negedge clk_i);
        chk("itlb_wait_cmd", mem_cmd_v_o, 0);
        chk("itlb_wait_ncmd", cmds.size() - bc, 3);
        tick(1);
        itlb_fill_done_i = 1'b1;
        tick(1);
        itlb_fill_done_i = 1'b0;
        tick(4);
        chk("itlb_reissue", at_cmd(bc + 3), 39'h3000);
        chk("itlb_deliver", at_got(b), 39'h3000);
        chk("itlb_nexc", epc.size() - be, 1);

        // page fault at 0x4010
        pf_pc = 39'h4010;
        b = got.size();
        redirect_to(39'h4000);
        tick(6);
        @(negedge clk_i);
        chk("pf_exc_v", exc_v_o, 1);
        chk("pf_code", exc_code_o, 2);
        chk("pf_pc", exc_pc_o, 39'h4010);
        chk("pf_fetch_v", fetch_v_o, 0);
        tick(4);
        @(negedge clk_i);
        chk("pf_hold_cmd", mem_cmd_v_o, 0);
        chk("pf_ndeliv", got.size() - b, 4);
        tick(1);
        b = got.size();
        redirect_to(39'h5000);
        tick(3);
        chk("pf_redir_pc", at_got(b), 39'h5000);

        // redirect with s1 and s2 both live
        b = got.size();
        redirect_v_i  = 1'b1;
        redirect_pc_i = 39'h7000;
        @(negedge clk_i);
        chk("rd_poison", mem_poison_o, 1);
        chk("rd_fetch_v", fetch_v_o, 0);
        chk("rd_exc_v", exc_v_o, 0);
        chk("rd_cmd_v", mem_cmd_v_o, 0);
        tick(1);
        redirect_v_i = 1'b0;
        tick(4);
        chk("rd_pc0", at_got(b), 39'h7000);
        chk("rd_pc1", at_got(b + 1), 39'h7004);

        // access fault outranks page fault and ITLB miss
        af_pc = 39'h6000;
        pf_pc = 39'h6000;
        tl_pc = 39'h6000;
        tl_tok++;
        redirect_to(39'h6000);
        tick(2);
        @(negedge clk_i);
        chk("prio_exc_v", exc_v_o, 1);
        chk("prio_code", exc_code_o, 1);
        chk("prio_pc", exc_pc_o, 39'h6000);
        tick(2);
        af_pc = 39'h1;
        pf_pc = 39'h1;

        // vaddr wrap
        b  = got.size();
        bc = cmds.size();
        redirect_to(39'h7FFFFFFFFC);
        tick(5);
        chk("wrap_cmd0", at_cmd(bc), 39'h7FFFFFFFFC);
        chk("wrap_cmd1", at_cmd(bc + 1), 0);
        chk("wrap_pc0", at_got(b), 39'h7FFFFFFFFC);
        chk("wrap_pc1", at_got(b + 1), 0);

        // mid-operation reset
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("mrst_fetch_v", fetch_v_o, 0);
        chk("mrst_cmd_v", mem_cmd_v_o, 0);
        tick(1);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("mrst_fetch_v1", fetch_v_o, 0);
        chk("mrst_exc_v1", exc_v_o, 0);
        chk("mrst_vaddr", mem_cmd_vaddr_o, 0);
        tick(3);

        // redirect and fill done together
        tl_pc = 39'h8000;
        tl_tok++;
        redirect_to(39'h8000);
        tick(4);
        b = got.size();
        redirect_v_i     = 1'b1;
        redirect_pc_i    = 39'h9000;
        itlb_fill_done_i = 1'b1;
        tick(1);
        redirect_v_i     = 1'b0;
        itlb_fill_done_i = 1'b0;
        tick(4);
        chk("rdfill_pc", at_got(b), 39'h9000);

        chk("excl_fetch_exc", both, 0);
        chk("instr_data", bad_instr, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_fetch_seq.md
Name: bp_fe_fetch_seq

Overview:
- Front-end fetch sequencer sitting directly upstream of the FE memory stage (ITLB + I$).
- Generates sequential fetch commands, tracks the fixed 2-cycle command→response pipeline, and poisons in-flight fetches on redirect, miss or backpressure.
- Consumes responses and delivers instructions or exceptions to the BE-facing fetch queue.
- Owns replay after I$ miss and the ITLB-miss wait.

Parameters:
- vaddr_width_p, 39, virtual address width.
- instr_width_p, 32, instruction width.
- pc_step_p, 4, byte increment between sequential fetches.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- redirect_v_i  in  1  BE redirect strobe
- redirect_pc_i  in  vaddr_width_p  redirect target
- itlb_fill_done_i  in  1  ITLB fill for the pending miss written
- mem_cmd_v_o  out  1  fetch command valid
- mem_cmd_vaddr_o  out  vaddr_width_p  fetch vaddr
- mem_cmd_yumi_i  in  1  memory stage accepted command
- mem_poison_o  out  1  squash the fetch accepted last cycle
- mem_resp_v_i  in  1  response valid
- mem_resp_icache_miss_i  in  1  response is an I$ miss
- mem_resp_itlb_miss_i  in  1  response is an ITLB miss
- mem_resp_access_fault_i  in  1  access fault
- mem_resp_page_fault_i  in  1  page fault
- mem_resp_data_i  in  instr_width_p  instruction
- fetch_v_o  out  1  instruction valid to queue
- fetch_pc_o  out  vaddr_width_p  instruction PC
- fetch_instr_o  out  instr_width_p  instruction
- fetch_ready_i  in  1  queue can accept this cycle
- exc_v_o  out  1  exception valid
- exc_code_o  out  2  0=itlb miss, 1=access fault, 2=page fault
- exc_pc_o  out  vaddr_width_p  faulting PC

Behaviour:
- States: RUN, ITLB_WAIT, FAULT. Reset → RUN.
- Reset values: next_pc=0, s1_v=s2_v=0, all outputs 0.
- Pipeline stages:
  - Command accepted at cycle N (mem_cmd_v_o & mem_cmd_yumi_i) → s1_v/s1_pc loaded.
  - N+1: s2 ← s1 unless mem_poison_o.
  - N+2: response expected; mem_resp_v_i without s2_v is ignored.
- mem_cmd_v_o = (state==RUN) & ~redirect_v_i; mem_cmd_vaddr_o = next_pc.
- On yumi: next_pc += pc_step_p, wrapping modulo 2^vaddr_width_p.
- Response classification, priority order: access fault > page fault > itlb miss > icache miss > good.
- Good response:
  - fetch_v_o = s2_v & mem_resp_v_i & fetch_ready_i; pc/instr combinational from s2_pc/data.
  - If fetch_ready_i=0: response dropped, next_pc ← s2_pc, mem_poison_o=1, no fetch_v_o.
- I$ miss: next_pc ← s2_pc, poison s1, stay RUN; refetch is re-issued when the memory stage accepts (yumi stalls while the fill is busy).
- ITLB miss: exc_v_o=1 code 0 for one cycle, next_pc ← s2_pc, poison s1, go ITLB_WAIT. ITLB_WAIT + itlb_fill_done_i → RUN.
- Faults: exc_v_o=1 code 1/2 for one cycle with exc_pc_o=s2_pc, poison s1, go FAULT. FAULT holds until redirect.
- Redirect (any state), highest priority:
  - next_pc ← redirect_pc_i, mem_poison_o=1, s2 response suppressed (no fetch_v_o/exc_v_o), state → RUN, no command that cycle.
  - Redirect + itlb_fill_done_i same cycle: redirect wins.
- mem_poison_o applies only when s1_v; otherwise 0. A poisoned s1 never reaches s2.
- fetch_v_o and exc_v_o are mutually exclusive.
- Mid-operation reset clears s1/s2 with no output that cycle or the next.

Test Plan:
- Reset, redirect to 0x8000_0000, yumi always, ready always, good responses → fetch_v_o every cycle from cycle 3: PCs 0x8000_0000, …_0004, …_0008.
- I$ miss on PC 0x1004 → poison asserted, next command vaddr 0x1004; output order 0x1000, 0x1004, 0x1008 with no duplicates.
- fetch_ready_i=0 on 0x2008 response → poison, 0x2008 refetched and delivered once when ready returns.
- ITLB miss at 0x3000 → exc_v_o code 0, pc 0x3000, no commands until itlb_fill_done_i, then vaddr 0x3000 issued.
- Page fault at 0x4010 → exc code 2; no commands until redirect to 0x5000; next fetch 0x5000.
- Redirect asserted while s1 and s2 are valid → s2 response suppressed, poison=1, first delivered PC is the redirect target.
- next_pc = 2^39−4 → following vaddr 0.
